// File: rtl/stereo_pkg.sv
// Shared types for the stereo SAD column path: default geometry, the per-camera
// column word and the queued column entry.
package stereo_pkg;

    localparam int DEF_KERNEL_WIDTH = 3;
    localparam int DEF_H_ACTIVE     = 320;

    // Index 0 is the oldest row, index DEF_KERNEL_WIDTH-1 the current row
    typedef logic [DEF_KERNEL_WIDTH-1:0][7:0] column_t;

    typedef struct packed {
        column_t     left;
        column_t     right;
        logic [10:0] h;
        logic [9:0]  v;
    } col_entry_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } sync_state_t;

endpackage

// File: rtl/column_fifo.sv
// Synchronous FIFO for queued columns. A push while full is accepted only
// when a pop happens in the same cycle; the caller never pops when empty.
module column_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_en   = push && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sad_column_feeder.sv
// Builds vertical pixel columns from lockstep left/right raster streams and
// issues them one at a time to the SAD engine under its busy handshake.
module sad_column_feeder
    import stereo_pkg::*;
#(
    parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [7:0]                      left_pixel_in,
    input  logic [7:0]                      right_pixel_in,
    input  logic [10:0]                     hcount_in,
    input  logic [9:0]                      vcount_in,
    input  logic                            pixel_valid_in,
    input  logic                            sad_busy_in,
    output logic [KERNEL_WIDTH*8-1:0]       left_data_out,
    output logic [KERNEL_WIDTH*8-1:0]       right_data_out,
    output logic [10:0]                     hcount_out,
    output logic [9:0]                      vcount_out,
    output logic                            data_valid_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_out,
    output logic                            overflow_out
);

    localparam int ROWS = KERNEL_WIDTH - 1;
    localparam int AW_H = $clog2(H_ACTIVE);

    logic [7:0]       lb_left  [ROWS][H_ACTIVE];
    logic [7:0]       lb_right [ROWS][H_ACTIVE];
    logic [AW_H-1:0]  addr;
    logic             accept;
    logic             frame_start;
    logic             push_req;

    sync_state_t      state;
    col_entry_t       entry_p1;
    col_entry_t       head;
    logic             push_p1;
    logic             cooldown;
    logic             full;
    logic             empty;
    logic             pop;

    assign accept      = pixel_valid_in && (hcount_in < 11'(H_ACTIVE));
    assign addr        = hcount_in[AW_H-1:0];
    assign frame_start = accept && (hcount_in == '0) && (vcount_in == '0);
    assign push_req    = accept && (state == RUN) && (vcount_in >= 10'(ROWS));

    // Cooldown covers the cycle the engine needs before its busy reflects the issue
    assign pop = !empty && !sad_busy_in && !cooldown;

    // Stage p0 -> p1: read stored rows at this column, then shift the new pixel in
    always_ff @(posedge clk_in) begin
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                entry_p1.left[r]  <= lb_left[r][addr];
                entry_p1.right[r] <= lb_right[r][addr];
            end
            entry_p1.left[ROWS]  <= left_pixel_in;
            entry_p1.right[ROWS] <= right_pixel_in;
            entry_p1.h           <= hcount_in;
            entry_p1.v           <= vcount_in - 10'(KERNEL_WIDTH / 2);
            for (int r = 0; r < ROWS - 1; r++) begin
                lb_left[r][addr]  <= lb_left[r+1][addr];
                lb_right[r][addr] <= lb_right[r+1][addr];
            end
            lb_left[ROWS-1][addr]  <= left_pixel_in;
            lb_right[ROWS-1][addr] <= right_pixel_in;
        end
    end

    column_fifo #(
        .WIDTH ($bits(col_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .push    (push_p1),
        .pop     (pop),
        .wr_data (entry_p1),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count_out)
    );

    // Stage p1 -> issue: frame sync, issue registers and sticky overflow
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= WAIT_FRAME;
            push_p1        <= 1'b0;
            cooldown       <= 1'b0;
            data_valid_out <= 1'b0;
            left_data_out  <= '0;
            right_data_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            overflow_out   <= 1'b0;
        end else begin
            if (state == WAIT_FRAME && frame_start) state <= RUN;
            push_p1        <= push_req;
            cooldown       <= pop;
            data_valid_out <= pop;
            if (pop) begin
                left_data_out  <= head.left;
                right_data_out <= head.right;
                hcount_out     <= head.h;
                vcount_out     <= head.v;
            end
            if (push_p1 && full && !pop) overflow_out <= 1'b1;
        end
    end

endmodule

// File: doc/sad_column_feeder.md
Name: sad_column_feeder

Overview:
- Producer side of the stereo SAD column interface.
- Takes the raster pixel streams from the left and right cameras, which arrive in lockstep, and stores the previous KERNEL_WIDTH-1 rows of each camera in line buffers.
- For each pixel it forms a vertical column of KERNEL_WIDTH pixels per camera and queues the column.
- It issues queued columns to the SAD engine one at a time, obeying that engine's busy handshake, so slow per-pixel disparity search never corrupts or loses pixel data while the queue has room.

Parameters:
- KERNEL_WIDTH, 3: column height, equal to the number of rows per column sent to the SAD engine.
- H_ACTIVE, 320: active pixels per line; line buffer depth.
- FIFO_DEPTH, 8: number of queued columns; power of two.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- left_pixel_in, input, 8: left camera grayscale pixel.
- right_pixel_in, input, 8: right camera grayscale pixel, same coordinate as the left pixel.
- hcount_in, input, 11: pixel column.
- vcount_in, input, 10: pixel row.
- pixel_valid_in, input, 1: pixel strobe.
- sad_busy_in, input, 1: SAD engine busy; no new column may be issued while it is high.
- left_data_out, output, KERNEL_WIDTH x 8: left column. Index 0 is row vcount-(KERNEL_WIDTH-1); index KERNEL_WIDTH-1 is the current row.
- right_data_out, output, KERNEL_WIDTH x 8: right column, same ordering.
- hcount_out, output, 11: column coordinate.
- vcount_out, output, 10: center row, equal to source vcount-(KERNEL_WIDTH/2).
- data_valid_out, output, 1: one-cycle issue strobe.
- fifo_count_out, output, $clog2(FIFO_DEPTH)+1: current queue occupancy.
- overflow_out, output, 1: sticky; set when a column is dropped.

Behaviour:
- Reset values: all outputs are 0. FIFO pointers and count are cleared, the cooldown register is cleared, and the frame-sync FSM enters WAIT_FRAME. Line buffer contents are not cleared; their values are don't-care.
- Reset has priority over every other event. A reset mid-frame discards queued columns and suppresses output until the next frame start.
- Acceptance: a pixel is accepted when pixel_valid_in is 1 and hcount_in < H_ACTIVE. Pixels with hcount_in >= H_ACTIVE are ignored entirely: no buffer write and no push.
- Line buffers, with one set per camera:
  - There are KERNEL_WIDTH-1 rows, organised as a shift-by-row structure addressed by hcount_in.
  - On an accepted pixel at cycle N, the stored rows at that address are read and the buffers are updated in the same cycle (read-before-write).
  - The assembled column is registered and pushed at N+1.
- Frame-sync FSM states:
  - WAIT_FRAME: no pushes occur. The FSM moves to RUN on the first accepted pixel with vcount_in==0 and hcount_in==0. That pixel is written into the line buffers.
  - RUN: a push occurs only when the accepted pixel has vcount_in >= KERNEL_WIDTH-1. Lower rows only fill the buffers.
- FIFO (width 2*KERNEL_WIDTH*8 + 21 bits):
  - Push and pop in the same cycle are legal at any occupancy, including full; count is unchanged.
  - A push when full with no pop drops the column and sets overflow_out, which stays high until rst_in.
  - A pop when empty cannot occur.
- Issue rule: a column is popped at cycle T when the FIFO is non-empty, sad_busy_in==0 and cooldown==0. Then:
  - data_valid_out=1 during T+1, with data, hcount_out and vcount_out valid in the same cycle.
  - cooldown is set for T+1. This is required because the SAD engine raises busy only one cycle after sampling its valid input.
  - data_valid_out is 0 in all other cycles. Data outputs hold their last value.
- Latency: with an empty FIFO, an idle engine and no cooldown, a pixel accepted at N produces data_valid_out at N+3: the column is registered at N+1, popped at N+2 and issued at N+3.
- Throughput: at most one issue every 2 cycles. In steady state, issues follow the SAD engine's busy pattern.
- Arithmetic: vcount_out = stored vcount - KERNEL_WIDTH/2 (integer division), computed at push time. It never underflows, because pushes require vcount >= KERNEL_WIDTH-1.

Decomposition:
- Package stereo_pkg holds:
  - KERNEL_WIDTH and H_ACTIVE defaults.
  - A typedef column_t for a KERNEL_WIDTH x 8 packed array.
  - A typedef col_entry_t as a struct {column_t left, right; logic [10:0] h; logic [9:0] v;}.
- Sub-module column_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, providing push, pop, full, empty and count.
- The line buffers and FSM are implemented inline in the top module.

Test Plan:
- Ramp frame: left = h+v, right = h+v+1, engine never busy. At h=5, v=2 expect left_data_out={5,6,7}, right_data_out={6,7,8}, vcount_out=1, and data_valid_out 3 cycles after the pixel.
- Row suppression: pixels on rows 0 and 1 only. Expect zero issues and fifo_count_out==0.
- Backpressure: hold sad_busy_in=1 for 20 cycles while pushing 4 pixels. Expect no issues and fifo_count_out=4. After release, expect 4 strobes, each separated by at least 2 cycles, in push order.
- Overflow: with busy held, push 9 columns. Expect the 9th dropped, overflow_out=1 and staying high, count=8, and the first 8 columns issued intact after release.
- Full with simultaneous pop: at count=8, busy drops in the same cycle a pixel arrives. Expect no overflow and count to remain 8.
- Mid-frame reset: assert rst_in at v=10. Expect all outputs 0 and no issues until a pixel at (0,0), then no issues until row 2 of the new frame. Pixels with h>=320 produce no pushes.
